// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code set 2 constants, key-bit positions and decoder state encoding
// for the PS/2 key decoder.
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_EXT          = 8'hE0;
  localparam logic [7:0] SC_BRK          = 8'hF0;
  localparam logic [7:0] SC_PAUSE        = 8'hE1;
  localparam logic [7:0] SC_ERR_LO       = 8'h00;
  localparam logic [7:0] SC_ERR_HI       = 8'hFF;
  localparam logic [7:0] SC_BAT_OK       = 8'hAA;
  localparam logic [7:0] SC_BAT_FAIL     = 8'hFC;
  localparam logic [7:0] SC_FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_FAKE_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_UP           = 8'h75;
  localparam logic [7:0] SC_DOWN         = 8'h72;
  localparam logic [7:0] SC_LEFT         = 8'h6B;
  localparam logic [7:0] SC_RIGHT        = 8'h74;
  localparam logic [7:0] SC_ENTER        = 8'h5A;
  localparam logic [7:0] SC_ESC          = 8'h76;

  // Bit positions match the main FSM's one-hot key encoding.
  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_DOWN  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_RIGHT = 3;
  localparam int unsigned KEY_ENTER = 4;
  localparam int unsigned KEY_ESC   = 5;
  localparam int unsigned KEY_W     = 6;

  // Bytes following E1 in the Pause make sequence (E1 14 77 E1 F0 14 F0 77).
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StSkip
  } state_e;

  function automatic logic is_clear_code(input logic [7:0] b);
    return (b == SC_ERR_LO) || (b == SC_ERR_HI) || (b == SC_BAT_OK) || (b == SC_BAT_FAIL);
  endfunction

endpackage

// File: rtl/ps2_scancode_map.sv
// Combinational lookup of (scan byte, extended flag) to a one-hot key bit;
// zero for keys the game does not use.
module ps2_scancode_map
  import ps2_key_decoder_pkg::*;
(
  input  logic [7:0]        code_i,
  input  logic              ext_i,
  output logic [KEY_W-1:0]  key_o
);

  always_comb begin
    key_o = '0;
    case (code_i)
      SC_UP:    key_o[KEY_UP]    = ext_i;
      SC_DOWN:  key_o[KEY_DOWN]  = ext_i;
      SC_LEFT:  key_o[KEY_LEFT]  = ext_i;
      SC_RIGHT: key_o[KEY_RIGHT] = ext_i;
      // Main-block and keypad Enter both count as ENTER.
      SC_ENTER: key_o[KEY_ENTER] = 1'b1;
      SC_ESC:   key_o[KEY_ESC]   = ~ext_i;
      default:  key_o = '0;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to held-key vector and last-make keycode, with
// prefix tracking, Pause discard, prefix timeout and error/BAT clear.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 6500000
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [KEY_W-1:0]  key,
  output logic [7:0]        keycode,
  output logic              key_event,
  output logic              seq_error
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d, state_eff;
  logic [CntW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [2:0]        skip_q, skip_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [7:0]        keycode_q, keycode_d;
  logic              keycode_ext_q, keycode_ext_d;
  logic              key_event_q, key_event_d;
  logic              seq_error_q, seq_error_d;
  logic              timeout;
  logic              ext;
  logic [KEY_W-1:0]  map_key;

  assign timeout = (state_q != StIdle) && (tmo_cnt_q == CntLast);
  // On expiry the current byte (if any) is decoded as though already in IDLE.
  assign state_eff = timeout ? StIdle : state_q;
  assign ext = (state_eff == StExt) || (state_eff == StExtBrk);

  ps2_scancode_map u_map (
    .code_i (rx_data),
    .ext_i  (ext),
    .key_o  (map_key)
  );

  always_comb begin
    state_d       = state_eff;
    skip_d        = skip_q;
    key_d         = key_q;
    keycode_d     = keycode_q;
    keycode_ext_d = keycode_ext_q;
    seq_error_d   = timeout;

    if (rx_valid) begin
      if (is_clear_code(rx_data)) begin
        key_d         = '0;
        keycode_d     = '0;
        keycode_ext_d = 1'b0;
        seq_error_d   = 1'b1;
        state_d       = StIdle;
      end else begin
        case (state_eff)
          StIdle: begin
            if (rx_data == SC_EXT) begin
              state_d = StExt;
            end else if (rx_data == SC_BRK) begin
              state_d = StBrk;
            end else if (rx_data == SC_PAUSE) begin
              state_d = StSkip;
              skip_d  = PAUSE_TAIL;
            end else begin
              key_d         = key_q | map_key;
              keycode_d     = rx_data;
              keycode_ext_d = 1'b0;
            end
          end
          StExt: begin
            if (rx_data == SC_BRK) begin
              state_d = StExtBrk;
            end else begin
              state_d = StIdle;
              if (rx_data != SC_FAKE_SHIFT_L && rx_data != SC_FAKE_SHIFT_R) begin
                key_d         = key_q | map_key;
                keycode_d     = rx_data;
                keycode_ext_d = 1'b1;
              end
            end
          end
          StBrk, StExtBrk: begin
            state_d = StIdle;
            key_d   = key_q & ~map_key;
            if (rx_data == keycode_q && ext == keycode_ext_q) begin
              keycode_d = '0;
            end
          end
          StSkip: begin
            skip_d = skip_q - 3'd1;
            if (skip_q <= 3'd1) begin
              state_d = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    tmo_cnt_d   = (rx_valid || state_d == StIdle) ? '0 : tmo_cnt_q + CntW'(1);
    key_event_d = (key_d != key_q);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= StIdle;
      tmo_cnt_q     <= '0;
      skip_q        <= '0;
      key_q         <= '0;
      keycode_q     <= '0;
      keycode_ext_q <= 1'b0;
      key_event_q   <= 1'b0;
      seq_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      skip_q        <= skip_d;
      key_q         <= key_d;
      keycode_q     <= keycode_d;
      keycode_ext_q <= keycode_ext_d;
      key_event_q   <= key_event_d;
      seq_error_q   <= seq_error_d;
    end
  end

  assign key       = key_q;
  assign keycode   = keycode_q;
  assign key_event = key_event_q;
  assign seq_error = seq_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and random byte streams into ps2_key_decoder, every cycle compared
// against a prefix-context model of the scan-code rules.
module tb_ps2_key_decoder;

  localparam int unsigned T = 40;

  logic       pclk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [5:0] key;
  logic [7:0] keycode;
  logic       key_event;
  logic       seq_error;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [5:0] m_key;
  logic [7:0] m_code;
  bit         m_code_ext;
  bit         m_evt;
  bit         m_err;
  bit         m_ext_pend;
  bit         m_brk_pend;
  int         m_skip;
  int         since;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .key       (key),
    .keycode   (keycode),
    .key_event (key_event),
    .seq_error (seq_error)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [5:0] ref_map(input logic [7:0] b, input bit e);
    if (e && b == 8'h75) return 6'b000001;
    if (e && b == 8'h72) return 6'b000010;
    if (e && b == 8'h6B) return 6'b000100;
    if (e && b == 8'h74) return 6'b001000;
    if (b == 8'h5A)      return 6'b010000;
    if (!e && b == 8'h76) return 6'b100000;
    return 6'b000000;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_key = '0; m_code = '0; m_code_ext = 0; m_evt = 0; m_err = 0;
    m_ext_pend = 0; m_brk_pend = 0; m_skip = 0; since = 0;
  endtask

  // Advance the model by one clock cycle, with or without a byte.
  task automatic model_cycle(input bit valid, input logic [7:0] b);
    logic [5:0] prev;
    prev = m_key;
    m_err = 0;
    since++;
    if ((m_ext_pend || m_brk_pend || m_skip > 0) && since >= T) begin
      m_ext_pend = 0; m_brk_pend = 0; m_skip = 0; m_err = 1;
    end
    if (valid) begin
      since = 0;
      if (b == 8'h00 || b == 8'hFF || b == 8'hAA || b == 8'hFC) begin
        m_key = '0; m_code = '0; m_code_ext = 0; m_err = 1;
        m_ext_pend = 0; m_brk_pend = 0; m_skip = 0;
      end else if (m_skip > 0) begin
        m_skip--;
      end else if (m_brk_pend) begin
        m_key = m_key & ~ref_map(b, m_ext_pend);
        if (b == m_code && m_ext_pend == m_code_ext) m_code = '0;
        m_ext_pend = 0; m_brk_pend = 0;
      end else if (m_ext_pend) begin
        if (b == 8'hF0) begin
          m_brk_pend = 1;
        end else begin
          if (b != 8'h12 && b != 8'h59) begin
            m_key = m_key | ref_map(b, 1); m_code = b; m_code_ext = 1;
          end
          m_ext_pend = 0;
        end
      end else if (b == 8'hE0) begin
        m_ext_pend = 1;
      end else if (b == 8'hF0) begin
        m_brk_pend = 1;
      end else if (b == 8'hE1) begin
        m_skip = 7;
      end else begin
        m_key = m_key | ref_map(b, 0); m_code = b; m_code_ext = 0;
      end
    end
    m_evt = (m_key != prev);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".key"}, {2'b00, key}, {2'b00, m_key});
    chk({tag, ".keycode"}, keycode, m_code);
    chk({tag, ".key_event"}, {7'd0, key_event}, {7'd0, m_evt});
    chk({tag, ".seq_error"}, {7'd0, seq_error}, {7'd0, m_err});
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    model_cycle(1, b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check_all($sformatf("byte_%02h", b));
    for (int i = 0; i < gap; i++) begin
      model_cycle(0, 8'h00);
      tick();
      check_all("gap");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    tick();
    model_reset();
    check_all("reset");
    rst = 1'b0;
  endtask

  logic [7:0] pool [16];

  initial begin
    pool = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
             8'h5A, 8'h76, 8'h1C, 8'h12, 8'h59, 8'hE1, 8'h29, 8'hAA};
    rx_data = 8'h00;
    rx_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    tick();
    do_reset();

    // UP make then break
    send(8'hE0, 1); send(8'h75, 1);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 2);
    // ENTER and LEFT held together, release ENTER
    send(8'h5A, 1); send(8'hE0, 1); send(8'h6B, 1);
    send(8'hF0, 1); send(8'h5A, 1);
    // unmapped key with typematic repeat
    send(8'h1C, 1); send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 1);
    send(8'hF0, 1); send(8'h1C, 1);
    // Pause sequence then RIGHT
    send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0); send(8'hE1, 0);
    send(8'hF0, 0); send(8'h14, 0); send(8'hF0, 0); send(8'h77, 1);
    send(8'hE0, 0); send(8'h74, 1);
    // timeout after E0, then ESC decoded as non-extended
    send(8'hE0, T + 4); send(8'h76, 1);
    // byte one cycle before expiry stays extended; byte on expiry is plain
    send(8'hE0, T - 2); send(8'h72, 1);
    send(8'hE0, T - 1); send(8'h75, 1);
    // hold UP, then BAT byte clears everything
    send(8'hE0, 0); send(8'h75, 1); send(8'hAA, 2);
    // reset mid-break sequence
    send(8'hE0, 0); send(8'hF0, 1);
    do_reset();
    send(8'h72, 2);

    for (int n = 0; n < 500; n++) begin
      int gap;
      int r;
      r = int'($urandom_range(0, 99));
      gap = (r < 3) ? (T - 2 + int'($urandom_range(0, 2))) : int'($urandom_range(0, 2));
      if (r == 99) do_reset();
      send(pool[$urandom_range(0, 15)], gap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the byte stream of a PS/2 keyboard (scan code set 2) into the held-key vector `key[5:0]` and the last-make `keycode[7:0]` that the menu/game state machine consumes. Sits between the PS/2 serial receiver, which delivers one byte per `rx_valid` strobe, and the main FSM. Tracks make/break and extended (E0) prefixes, discards the Pause (E1) sequence, recovers from truncated sequences via a timeout, and clears all keys on keyboard error or self-test bytes.

## Interface
- `TIMEOUT_CYCLES`, 6500000: idle cycles (≈100 ms at 65 MHz) after a prefix byte before the partial sequence is dropped.
- `pclk` in 1: pixel/system clock.
- `rst` in 1: reset. Synchronous, active-high; clock `pclk`.
- `rx_data` in 8: received byte, valid only when `rx_valid`=1.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `key` out 6: held-key vector. Bit0 UP (E0 75), bit1 DOWN (E0 72), bit2 LEFT (E0 6B), bit3 RIGHT (E0 74), bit4 ENTER (5A or E0 5A), bit5 ESC (76). Multiple bits may be set.
- `keycode` out 8: base byte of the most recent make code; 0 when that key is released.
- `key_event` out 1: one-cycle pulse whenever `key` changes value.
- `seq_error` out 1: one-cycle pulse on timeout or on an error/BAT byte.

## Operation
- States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (E1 seen).
- IDLE: E0→EXT; F0→BRK; E1→SKIP with skip counter = 7; 00/FF/AA/FC→clear; any other byte b = make(b, ext=0).
- EXT: F0→EXT_BRK; 12 or 59 (fake shift) → IDLE, ignored; other b = make(b, ext=1) → IDLE.
- BRK: b = break(b, ext=0) → IDLE. EXT_BRK: b = break(b, ext=1) → IDLE.
- SKIP: each byte decrements counter; on reaching 0 → IDLE. No key effect.
- make(b,e): set mapped `key` bit if (b,e) is in the table; `keycode`←b; store e in internal `keycode_ext`. Mapped or not, `keycode` updates.
- break(b,e): clear mapped bit; if b==`keycode` and e==`keycode_ext`, `keycode`←0.
- Typematic repeat (make of already-held key): `key` unchanged, no `key_event`; `keycode` rewritten.
- Clear (error/BAT byte 00, FF, AA, FC from any state): `key`←0, `keycode`←0, `seq_error` pulse, → IDLE.
- Prefix bytes inside EXT/BRK/EXT_BRK other than those listed are treated as the data byte (no nesting).

## Timing
- Reset values: `key`=0, `keycode`=0, `key_event`=0, `seq_error`=0, state IDLE, timeout counter 0, skip counter 0.
- All outputs registered; `key`/`keycode` update on the first `pclk` edge after the cycle in which the final byte's `rx_valid` is sampled (latency 1). `key_event` asserted in the same cycle as the new `key` value.
- Timeout counter runs only in EXT, BRK, EXT_BRK, SKIP; cleared on every `rx_valid` and on entry to IDLE. When it reaches `TIMEOUT_CYCLES`-1 without `rx_valid`: → IDLE, `seq_error` pulse, `key`/`keycode` unchanged.
- Simultaneous timeout expiry and `rx_valid`: timeout wins; the byte is interpreted from IDLE in that same cycle, `seq_error` pulses.
- `rx_valid` on consecutive cycles is supported; every byte is consumed.
- `rst` mid-sequence: prefix context discarded, all keys released; the next byte is decoded from IDLE.

## Structure
- Shared package: scan code constants (E0, F0, E1, error/BAT codes, arrow/enter/esc codes), `KEY_*` bit positions matching the main FSM's one-hot encodings, state encoding typedef.
- One sub-module natural: `ps2_scancode_map`, combinational (byte, ext) → 6-bit one-hot or 0 for unmapped.
- Timeout counter width = $clog2(TIMEOUT_CYCLES); skip counter 3 bits.

## Test plan
- E0 75 → `key`=000001, `keycode`=75, one `key_event`; then E0 F0 75 → `key`=0, `keycode`=00, one `key_event`.
- 5A, then E0 6B (both held) → `key`=010100, `keycode`=6B; F0 5A → `key`=000100, `keycode` stays 6B.
- 1C (unmapped A) → `key`=0, `keycode`=1C, no `key_event`; repeat 1C ×3 → no change; F0 1C → `keycode`=0.
- E1 14 77 E1 F0 14 F0 77, then E0 74 → Pause ignored, `key`=001000 after the last byte.
- E0 then silence for `TIMEOUT_CYCLES` → `seq_error` pulse, state IDLE; next byte 76 → `key`=100000 (not treated as extended).
- Hold UP, send AA → `key`=0, `keycode`=0, `seq_error` and `key_event` pulse; assert `rst` after E0 F0 → next 72 sets no bit and `keycode`=72.
